// File: rtl/freelist_pkg.sv
// freelist_pkg: shared rename-frontend sizes and free-list pointer types
package freelist_pkg;
    localparam int RENAME_WIDTH       = 4;
    localparam int COMMIT_WIDTH       = 4;
    localparam int PRF_INT_SIZE       = 64;
    localparam int ARF_INT_SIZE       = 32;
    localparam int RAT_CP_SIZE        = 4;
    localparam int PRF_INT_INDEX_SIZE = $clog2(PRF_INT_SIZE);
    localparam int RAT_CP_INDEX_SIZE  = $clog2(RAT_CP_SIZE);
    localparam int RENAME_CNT_SIZE    = $clog2(RENAME_WIDTH + 1);
    localparam int COMMIT_CNT_SIZE    = $clog2(COMMIT_WIDTH + 1);
    typedef logic [PRF_INT_INDEX_SIZE-1:0] prf_idx_t;
    typedef logic [PRF_INT_INDEX_SIZE:0]   fl_ptr_t;
endpackage

// File: rtl/freelist_prefix_popcount.sv
// prefix_popcount: per-lane count of set request bits below the lane, plus total
module prefix_popcount #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]         i_req,
    output logic [W-1:0][CW-1:0] o_off,
    output logic [CW-1:0]        o_total
);
    // running sum: each lane sees the count accumulated before it
    always_comb begin
        o_off   = '0;
        o_total = '0;
        for (int i = 0; i < W; i++) begin
            o_off[i] = o_total;
            o_total  = o_total + CW'(i_req[i]);
        end
    end
endmodule

// File: rtl/freelist.sv
// freelist: ring of free integer PRFs with compacted multi-lane alloc/free and head checkpoints
module freelist
    import freelist_pkg::*;
(
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [RENAME_WIDTH-1:0]              alloc_req,
    output prf_idx_t [RENAME_WIDTH-1:0]          alloc_prf,
    output logic                                 allocatable,
    input  logic [COMMIT_WIDTH-1:0]              free_req,
    input  prf_idx_t [COMMIT_WIDTH-1:0]          free_prf,
    input  logic                                 check,
    input  logic [RAT_CP_INDEX_SIZE-1:0]         check_idx,
    input  logic                                 recover,
    input  logic [RAT_CP_INDEX_SIZE-1:0]         recover_idx,
    output logic [PRF_INT_INDEX_SIZE:0]          free_count
);
    prf_idx_t r_ring [PRF_INT_SIZE];
    fl_ptr_t  r_slot [RAT_CP_SIZE];
    fl_ptr_t  r_head, r_tail;
    fl_ptr_t  w_head_alloc, w_head_next;
    logic [RENAME_WIDTH-1:0][RENAME_CNT_SIZE-1:0] w_alloc_off;
    logic [COMMIT_WIDTH-1:0][COMMIT_CNT_SIZE-1:0] w_free_off;
    logic [RENAME_CNT_SIZE-1:0] w_alloc_n;
    logic [COMMIT_CNT_SIZE-1:0] w_free_n;

    prefix_popcount #(.W(RENAME_WIDTH)) u_alloc_pc (
        .i_req   (alloc_req),
        .o_off   (w_alloc_off),
        .o_total (w_alloc_n)
    );

    prefix_popcount #(.W(COMMIT_WIDTH)) u_free_pc (
        .i_req   (free_req),
        .o_off   (w_free_off),
        .o_total (w_free_n)
    );

    assign free_count   = r_tail - r_head;
    assign allocatable  = (fl_ptr_t'(w_alloc_n) <= free_count) && !recover;
    assign w_head_alloc = allocatable ? r_head + fl_ptr_t'(w_alloc_n) : r_head;
    assign w_head_next  = recover ? r_slot[recover_idx] : w_head_alloc;

    // compacted grants: requesting lanes read consecutive entries from head
    always_comb begin
        alloc_prf = '0;
        for (int i = 0; i < RENAME_WIDTH; i++)
            alloc_prf[i] = alloc_req[i]
                ? r_ring[r_head[PRF_INT_INDEX_SIZE-1:0] + prf_idx_t'(w_alloc_off[i])] : '0;
    end

    // ring storage: PRFs above the architectural set start free; frees append at tail
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < PRF_INT_SIZE; k++)
                r_ring[k] <= (k < ARF_INT_SIZE) ? prf_idx_t'(k + ARF_INT_SIZE) : '0;
        end else begin
            for (int j = 0; j < COMMIT_WIDTH; j++)
                if (free_req[j])
                    r_ring[r_tail[PRF_INT_INDEX_SIZE-1:0] + prf_idx_t'(w_free_off[j])] <= free_prf[j];
        end
    end

    // pointers and checkpoints; a check snapshots head after this cycle's allocation
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head <= '0;
            r_tail <= fl_ptr_t'(ARF_INT_SIZE);
            for (int s = 0; s < RAT_CP_SIZE; s++)
                r_slot[s] <= '0;
        end else begin
            assert (free_count + fl_ptr_t'(w_free_n) <= fl_ptr_t'(PRF_INT_SIZE))
                else $error("freelist overflow: free_count=%0d freed=%0d", free_count, w_free_n);
            r_head <= w_head_next;
            r_tail <= r_tail + fl_ptr_t'(w_free_n);
            if (check && !recover)
                r_slot[check_idx] <= w_head_alloc;
        end
    end
endmodule
